line_mem_arbiter: RTL and testbench



---
 rtl/line_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_line_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit burst memory port between the I-cache and D-cache.
// Whole 256-bit lines are split into four beats on writes and assembled from four beats on reads.
module line_mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_addr,
    input  logic         i_read,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic [31:0]  d_addr,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);
    typedef enum logic [2:0] {StIdle, StRdIssue, StRdWait, StWrBurst, StDone} state_e;
    typedef enum logic {GrantI = 1'b0, GrantD = 1'b1} grant_e;

    state_e       state_q, state_d;
    grant_e       grant_q, grant_d;
    grant_e       last_grant_q, last_grant_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [26:0]  line_addr_q, line_addr_d;
    logic [255:0] line_q, line_d;

    logic i_pend, d_pend, pick_d;
    logic unused_addr_bits;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;
    // D wins when alone, or on a tie when I was served last.
    assign pick_d = d_pend && (!i_pend || (last_grant_q == GrantI));

    assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0], bmem_raddr};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        line_addr_d  = line_addr_q;
        line_d       = line_q;
        unique case (state_q)
            StIdle: begin
                if (i_pend || d_pend) begin
                    cnt_d = 2'd0;
                    if (pick_d) begin
                        grant_d     = GrantD;
                        line_addr_d = d_addr[31:5];
                        if (d_write) begin
                            line_d  = d_wdata;
                            state_d = StWrBurst;
                        end else begin
                            state_d = StRdIssue;
                        end
                    end else begin
                        grant_d     = GrantI;
                        line_addr_d = i_addr[31:5];
                        state_d     = StRdIssue;
                    end
                end
            end
            StRdIssue: begin
                if (bmem_ready) state_d = StRdWait;
            end
            StRdWait: begin
                if (bmem_rvalid) begin
                    line_d[{cnt_q, 6'd0} +: 64] = bmem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StDone;
                end
            end
            StWrBurst: begin
                if (bmem_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StDone;
                end
            end
            StDone: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= GrantI;
            last_grant_q <= GrantI;
            cnt_q        <= 2'd0;
            line_addr_q  <= 27'd0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            line_addr_q  <= line_addr_d;
            line_q       <= line_d;
        end
    end

    always_comb begin
        bmem_read  = (state_q == StRdIssue);
        bmem_write = (state_q == StWrBurst);
        bmem_wdata = bmem_write ? line_q[{cnt_q, 6'd0} +: 64] : 64'd0;
        i_resp     = (state_q == StDone) && (grant_q == GrantI);
        d_resp     = (state_q == StDone) && (grant_q == GrantD);
    end

    assign bmem_addr = {line_addr_q, 5'b0};
    assign i_rdata   = line_q;
    assign d_rdata   = line_q;

    // A simultaneous D read and write is a cache-side bug; the write is still served.
    a_no_d_rw: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
    a_raddr: assert property (@(posedge clk) disable iff (rst)
        (state_q == StRdWait && bmem_rvalid) |-> (bmem_raddr[31:5] == line_addr_q));

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Randomized bench for line_mem_arbiter: line-level memory model, two cache requesters,
// a fairness rule derived from round-robin arbitration, plus directed timing scenarios.
module tb_line_mem_arbiter;
    logic         clk;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    line_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (i_addr),
        .i_read      (i_read),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_addr      (d_addr),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Memory model: whole lines keyed by line index; untouched lines hold a fixed pattern.
    logic [255:0] mem [int unsigned];

    function automatic logic [255:0] line_of(input logic [31:0] a);
        int unsigned  idx;
        logic [255:0] l;
        idx = {5'd0, a[31:5]};
        if (mem.exists(idx)) return mem[idx];
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = {idx * 32'h9E37_79B1, idx[29:0], 2'(k)};
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] rand_addr();
        return {20'h60000, 7'($urandom_range(15)), 5'($urandom())};
    endfunction

    int cyc = 0;
    // memory responder controls and state
    int          ready_pct    = 100;
    int          ready_low_at = -1;
    int          rv_gap       = 0;
    bit          stray_next   = 0;
    bit          rd_active    = 0;
    int          rd_beat      = 0;
    int          rd_wait      = 0;
    logic [31:0] rd_addr      = '0;
    logic [31:0] last_rd_addr = '0;
    int          wr_beat      = 0;
    logic [31:0] wr_addr      = '0;
    logic [255:0] wr_line     = '0;
    int          n_rd_cyc     = 0;
    int          first_rd_cyc = -1;
    int          last_beat_cyc = -1;
    int          wr_beat_cyc[$];
    logic [63:0] wr_seq[$];
    // requester controls and state
    int           req_pct  = 100;
    bit           rand_req = 0;
    int           i_todo = 0, d_todo = 0;
    int           i_since = 0, d_since = 0, i_last = -1, d_last = -1;
    int           i_done = 0, d_done = 0, n_i_resp = 0, n_d_resp = 0;
    int           i_resp_cyc = -1, d_resp_cyc = -1;
    logic [31:0]  i_next_addr = '0, d_next_addr = '0;
    bit           d_next_write = 0;
    logic [255:0] d_next_wdata = '0;
    logic [255:0] last_i_rdata = '0;
    int           resp_log[$];

    // One clock of bench activity, entered and left at a falling edge.
    task automatic tick();
        logic [255:0] l;
        bit           wr;
        if (i_resp) begin
            n_i_resp++;
            i_resp_cyc = cyc;
            resp_log.push_back(0);
            last_i_rdata = i_rdata;
            check("i_resp_req", i_read, 1'b1);
            if (i_read) begin
                check("i_rdata", i_rdata, line_of(i_addr));
                check("i_fair", (d_read || d_write) && d_since <= i_last, 1'b0);
                i_last = cyc;
                i_read = 1'b0;
                i_done++;
            end
        end
        if (d_resp) begin
            n_d_resp++;
            d_resp_cyc = cyc;
            resp_log.push_back(1);
            check("d_resp_req", d_read || d_write, 1'b1);
            if (d_read || d_write) begin
                if (d_write) check("d_wb_mem", line_of(d_addr), d_wdata);
                else         check("d_rdata", d_rdata, line_of(d_addr));
                check("d_fair", i_read && i_since <= d_last, 1'b0);
                d_last  = cyc;
                d_read  = 1'b0;
                d_write = 1'b0;
                d_done++;
            end
        end
        if (!i_read && !i_resp && i_todo > 0 && $urandom_range(99) < req_pct) begin
            i_addr  = rand_req ? rand_addr() : i_next_addr;
            i_read  = 1'b1;
            i_since = cyc;
            i_todo--;
        end
        if (!(d_read || d_write) && !d_resp && d_todo > 0 && $urandom_range(99) < req_pct) begin
            wr      = rand_req ? 1'($urandom_range(1)) : d_next_write;
            d_addr  = rand_req ? rand_addr() : d_next_addr;
            d_wdata = rand_req ? rand_line() : d_next_wdata;
            d_write = wr;
            d_read  = !wr;
            d_since = cyc;
            d_todo--;
        end
        // memory side
        bmem_ready  = ($urandom_range(99) < ready_pct) && (cyc != ready_low_at);
        bmem_rvalid = 1'b0;
        if (rd_active) begin
            if (rd_wait > 0) begin
                rd_wait--;
            end else begin
                l           = line_of(rd_addr);
                bmem_rvalid = 1'b1;
                bmem_rdata  = l[rd_beat*64 +: 64];
                bmem_raddr  = {rd_addr[31:5], 2'(rd_beat), 3'b0};
                if (rd_beat == 3) last_beat_cyc = cyc;
                rd_beat++;
                if (rd_beat == 4) rd_active = 0;
                rd_wait = (rv_gap < 0) ? $urandom_range(2) : rv_gap;
            end
        end else if (stray_next) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = {$urandom(), $urandom()};
            bmem_raddr  = $urandom();
            stray_next  = 0;
        end
        if (bmem_read) begin
            if (n_rd_cyc == 0) first_rd_cyc = cyc;
            n_rd_cyc++;
        end
        if (bmem_read && bmem_ready) begin
            check("rd_addr_src", (i_read && bmem_addr == {i_addr[31:5], 5'b0}) ||
                                 (d_read && bmem_addr == {d_addr[31:5], 5'b0}), 1'b1);
            last_rd_addr = bmem_addr;
            rd_addr      = bmem_addr;
            rd_active    = 1;
            rd_beat      = 0;
            rd_wait      = (rv_gap < 0) ? $urandom_range(2) : rv_gap;
        end
        if (bmem_write && bmem_ready) begin
            if (wr_beat == 0) wr_addr = bmem_addr;
            else check("wr_addr_hold", bmem_addr, wr_addr);
            check("wr_beat_data", bmem_wdata, d_wdata[wr_beat*64 +: 64]);
            wr_beat_cyc.push_back(cyc);
            wr_seq.push_back(bmem_wdata);
            wr_line[wr_beat*64 +: 64] = bmem_wdata;
            wr_beat++;
            if (wr_beat == 4) begin
                mem[{5'd0, wr_addr[31:5]}] = wr_line;
                wr_beat = 0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input int ni, input int nd, input int budget, input string tag);
        int t0;
        t0 = cyc;
        while ((i_done < ni || d_done < nd) && (cyc - t0) < budget) tick();
        check(tag, i_done + d_done, ni + nd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_todo = 0; d_todo = 0;
        rd_active = 0; wr_beat = 0; stray_next = 0;
        i_last = -1; d_last = -1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_bmem_read"}, bmem_read, 1'b0);
        check({tag, "_bmem_write"}, bmem_write, 1'b0);
        check({tag, "_bmem_wdata"}, bmem_wdata, 64'd0);
        check({tag, "_bmem_addr"}, bmem_addr, 32'd0);
        check({tag, "_i_resp"}, i_resp, 1'b0);
        check({tag, "_d_resp"}, d_resp, 1'b0);
        check({tag, "_i_rdata"}, i_rdata, 256'd0);
        check({tag, "_d_rdata"}, d_rdata, 256'd0);
    endtask

    initial begin
        int           c0, ni, nd;
        logic [255:0] fresh;
        rst = 1'b1;
        i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        @(negedge clk);
        do_reset();
        check_quiet("reset");

        // Single I read, memory always ready, back-to-back beats.
        mem[{5'd0, 27'h300_0001}] =
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
        i_next_addr = 32'h6000_0024;
        n_rd_cyc = 0;
        c0 = cyc;
        ni = i_done + 1;
        i_todo = 1;
        run_until(ni, d_done, 50, "t1_done");
        repeat (2) tick();
        check("t1_bmem_addr", last_rd_addr, 32'h6000_0020);
        check("t1_read_cycles", n_rd_cyc, 1);
        check("t1_read_at", first_rd_cyc, c0 + 1);
        check("t1_rdata", last_i_rdata,
              256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        check("t1_last_beat", last_beat_cyc, c0 + 5);
        check("t1_resp_at", i_resp_cyc, c0 + 6);
        check("t1_resp_count", n_i_resp, 1);

        // D writeback, first with ready always high, then with one low-ready cycle.
        for (int pass = 0; pass < 2; pass++) begin
            d_next_addr  = 32'h6000_0100 + 32'(pass) * 32'h40;
            d_next_write = 1'b1;
            d_next_wdata = {{8{8'hA3}}, {8{8'hA2}}, {8{8'hA1}}, {8{8'hA0}}};
            wr_beat_cyc.delete();
            wr_seq.delete();
            c0 = cyc;
            ready_low_at = (pass == 1) ? c0 + 2 : -1;
            nd = d_done + 1;
            d_todo = 1;
            run_until(i_done, nd, 50, "t2_done");
            check("t2_beats", wr_beat_cyc.size(), 4);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t2_beat%0d_data", k), wr_seq[k], {8{8'hA0 + 8'(k)}});
                check($sformatf("t2_beat%0d_at", k), wr_beat_cyc[k],
                      c0 + 1 + k + ((pass == 1 && k > 0) ? 1 : 0));
            end
            check("t2_resp_at", d_resp_cyc, c0 + 5 + pass);
        end
        ready_low_at = -1;

        // Simultaneous requests after reset: D first; D re-requests while I waits -> I, then D.
        do_reset();
        resp_log.delete();
        i_next_addr  = 32'h6000_0200;
        d_next_addr  = 32'h6000_0240;
        d_next_write = 1'b0;
        ni = i_done + 1;
        nd = d_done + 2;
        i_todo = 1;
        d_todo = 2;
        run_until(ni, nd, 100, "t3_done");
        check("t3_order_len", resp_log.size(), 3);
        check("t3_first_d", resp_log[0], 1);
        check("t3_then_i", resp_log[1], 0);
        check("t3_then_d", resp_log[2], 1);

        // Gapped read beats with a stray rvalid while idle.
        rv_gap = 3;
        stray_next = 1;
        i_next_addr = 32'h6000_0300;
        c0 = n_i_resp;
        ni = i_done + 1;
        i_todo = 1;
        run_until(ni, d_done, 100, "t4_done");
        repeat (3) tick();
        check("t4_resp_count", n_i_resp - c0, 1);
        check("t4_resp_at", i_resp_cyc, last_beat_cyc + 1);
        check("t4_rdata", last_i_rdata, line_of(32'h6000_0300));

        // Reset while the second read beat is on the bus.
        rv_gap = 0;
        i_next_addr = 32'h6000_0380;
        i_todo = 1;
        c0 = 0;
        while (!(rd_active && rd_beat == 1) && c0 < 50) begin
            tick();
            c0++;
        end
        check("t5_reached_beat1", rd_beat, 1);
        rst = 1'b1;
        i_read = 1'b0;
        i_todo = 0;
        c0 = n_i_resp;
        tick();
        check_quiet("t5_reset");
        rst = 1'b0;
        i_last = -1;
        d_last = -1;
        repeat (4) tick();
        check("t5_no_resp", n_i_resp, c0);
        fresh = rand_line();
        mem[{5'd0, 27'h300_001C}] = fresh;
        ni = i_done + 1;
        i_todo = 1;
        run_until(ni, d_done, 50, "t5_done");
        check("t5_fresh", last_i_rdata, fresh);

        // Random continuous streams from both caches.
        rand_req  = 1;
        req_pct   = 30;
        ready_pct = 75;
        rv_gap    = -1;
        ni = i_done + 500;
        nd = d_done + 500;
        i_todo = 500;
        d_todo = 500;
        run_until(ni, nd, 60000, "rand_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
